// File: rtl/fetch_aligner.sv
// fetch_aligner: fetches 32-bit words from the I-cache into a three-halfword
// buffer and presents one instruction per handshake (16-bit compressed or
// 32-bit, possibly straddling a word boundary) together with its PC.
// Compressed instructions are only flagged here; expansion is done downstream.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ICACHE_ren      read request (forced low while rst is high)
//   ICACHE_addr     word address of the request
//   ICACHE_rdata    read data, valid when ICACHE_ren & ~ICACHE_stall
//   ICACHE_stall    cache busy; request is held stable while high
//   redirect_valid  redirect from execute, target in redirect_pc
//   inst_valid      inst_data / inst_is_c / inst_pc are valid
//   inst_ready      decode accepts the presented instruction
//   inst_data       {hw1,hw0} for 32-bit, {16'h0,hw0} for compressed
//   inst_is_c       head halfword is a compressed instruction
//   inst_pc         byte PC of the presented instruction
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ICACHE_ren,
  output logic [29:0] ICACHE_addr,
  input  logic [31:0] ICACHE_rdata,
  input  logic        ICACHE_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic        inst_is_c,
  output logic [31:0] inst_pc
);

  logic [47:0] buf_q, buf_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [29:0] fetch_word_q, fetch_word_d;
  logic [29:0] target_word_q, target_word_d;
  logic        skip_q, skip_d;
  logic        drop_q, drop_d;

  logic        head_is_c;
  logic [1:0]  need;
  logic        accept;
  logic        deq;
  logic [1:0]  cnt_deq;
  logic [47:0] buf_deq;
  logic [47:0] buf_app;

  assign head_is_c   = buf_q[1:0] != 2'b11;
  assign need        = head_is_c ? 2'd1 : 2'd2;
  assign inst_valid  = (cnt_q >= need) & ~drop_q;
  assign inst_is_c   = head_is_c;
  assign inst_data   = head_is_c ? {16'h0000, buf_q[15:0]} : buf_q[31:0];
  assign inst_pc     = head_pc_q;

  // Only request when the buffer can take a full word after any dequeue;
  // a pending drop must always complete so the cache is never left hanging.
  assign ICACHE_ren  = ~rst & (drop_q | (cnt_q <= 2'd1));
  assign ICACHE_addr = fetch_word_q;
  assign accept      = ICACHE_ren & ~ICACHE_stall;
  assign deq         = inst_valid & inst_ready;

  always_comb begin
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    head_pc_d     = head_pc_q;
    fetch_word_d  = fetch_word_q;
    target_word_d = target_word_q;
    skip_d        = skip_q;
    drop_d        = drop_q;

    // Buffer after the dequeue of this cycle.
    buf_deq = buf_q;
    cnt_deq = cnt_q;
    if (deq) begin
      cnt_deq = cnt_q - need;
      buf_deq = head_is_c ? {16'h0000, buf_q[47:16]} : {32'h0000_0000, buf_q[47:32]};
    end

    // Append lands right after the post-dequeue contents (at most one halfword).
    buf_app = buf_deq;
    if (skip_q) begin
      case (cnt_deq)
        2'd0:    buf_app[15:0]  = ICACHE_rdata[31:16];
        2'd1:    buf_app[31:16] = ICACHE_rdata[31:16];
        default: buf_app        = buf_deq;
      endcase
    end else begin
      case (cnt_deq)
        2'd0:    buf_app[31:0]  = ICACHE_rdata;
        2'd1:    buf_app[47:16] = ICACHE_rdata;
        default: buf_app        = buf_deq;
      endcase
    end

    if (redirect_valid) begin
      cnt_d         = 2'd0;
      head_pc_d     = redirect_pc & ~32'h1;
      skip_d        = redirect_pc[1];
      target_word_d = redirect_pc[31:2];
      if (ICACHE_ren & ICACHE_stall) begin
        // Stalled access must finish unchanged; its data gets thrown away.
        drop_d = 1'b1;
      end else begin
        fetch_word_d = redirect_pc[31:2];
        drop_d       = 1'b0;
      end
    end else begin
      buf_d     = buf_deq;
      cnt_d     = cnt_deq;
      head_pc_d = head_pc_q + (deq ? {29'h0, need, 1'b0} : 32'h0);
      if (accept) begin
        if (drop_q) begin
          drop_d       = 1'b0;
          fetch_word_d = target_word_q;
        end else begin
          buf_d         = buf_app;
          cnt_d         = cnt_deq + (skip_q ? 2'd1 : 2'd2);
          skip_d        = 1'b0;
          fetch_word_d  = fetch_word_q + 30'd1;
          target_word_d = target_word_q + 30'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q         <= '0;
      cnt_q         <= 2'd0;
      head_pc_q     <= RESET_PC;
      fetch_word_q  <= RESET_PC[31:2];
      target_word_q <= RESET_PC[31:2];
      skip_q        <= RESET_PC[1];
      drop_q        <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      head_pc_q     <= head_pc_d;
      fetch_word_q  <= fetch_word_d;
      target_word_q <= target_word_d;
      skip_q        <= skip_d;
      drop_q        <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
module tb_fetch_aligner;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        inst_is_c;
  logic [31:0] inst_pc;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  // Zero-latency cache: data for the presented address.
  assign ICACHE_rdata = mem[ICACHE_addr[7:0]];

  fetch_aligner #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .ICACHE_ren     (ICACHE_ren),
    .ICACHE_addr    (ICACHE_addr),
    .ICACHE_rdata   (ICACHE_rdata),
    .ICACHE_stall   (ICACHE_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_is_c      (inst_is_c),
    .inst_pc        (inst_pc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: halfword queue plus fetch pointers.
  logic [15:0] mq[$];
  logic [31:0] m_head;
  logic [29:0] m_fetch, m_target;
  logic        m_skip, m_drop;
  bit          armed = 0;
  logic        m_ren_v, m_acc, m_dq;
  int          m_n;
  logic [31:0] m_w;

  function automatic int m_need();
    if (mq.size() > 0 && mq[0][1:0] != 2'b11) return 1;
    return 2;
  endfunction

  function automatic bit m_valid();
    return !m_drop && (mq.size() >= m_need());
  endfunction

  function automatic bit m_ren();
    return !rst && (m_drop || mq.size() <= 1);
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_head   = RESET_PC;
      m_fetch  = RESET_PC[31:2];
      m_target = RESET_PC[31:2];
      m_skip   = RESET_PC[1];
      m_drop   = 1'b0;
      armed    = 1;
    end else begin
      m_ren_v = m_ren();
      m_acc   = m_ren_v && !ICACHE_stall;
      m_n     = m_need();
      m_dq    = m_valid() && inst_ready;
      if (redirect_valid) begin
        mq.delete();
        m_head   = {redirect_pc[31:1], 1'b0};
        m_skip   = redirect_pc[1];
        m_target = redirect_pc[31:2];
        if (m_ren_v && ICACHE_stall) m_drop = 1'b1;
        else begin
          m_fetch = redirect_pc[31:2];
          m_drop  = 1'b0;
        end
      end else begin
        if (m_dq) begin
          repeat (m_n) void'(mq.pop_front());
          m_head = m_head + 32'(2 * m_n);
        end
        if (m_acc) begin
          if (m_drop) begin
            m_drop  = 1'b0;
            m_fetch = m_target;
          end else begin
            m_w = mem[m_fetch[7:0]];
            if (!m_skip) mq.push_back(m_w[15:0]);
            mq.push_back(m_w[31:16]);
            m_skip   = 1'b0;
            m_fetch  = m_fetch + 30'd1;
            m_target = m_target + 30'd1;
          end
        end
      end
    end
  end

  // Handshake log, used for the hand-computed expectations.
  logic [31:0] lg_pc[$];
  logic [31:0] lg_data[$];
  logic        lg_c[$];
  int          lg_cyc[$];
  int          cyc = 0;
  logic        e_ren, e_valid;

  initial forever begin
    @(negedge clk);
    if (armed) begin
      e_ren = m_ren();
      chk("ren", {31'h0, ICACHE_ren}, {31'h0, e_ren});
      if (e_ren) chk("addr", {2'b00, ICACHE_addr}, {2'b00, m_fetch});
      e_valid = m_valid();
      chk("valid", {31'h0, inst_valid}, {31'h0, e_valid});
      chk("pc", inst_pc, m_head);
      if (e_valid) begin
        if (m_need() == 1) begin
          chk("data", inst_data, {16'h0000, mq[0]});
          chk("is_c", {31'h0, inst_is_c}, 32'h1);
        end else begin
          chk("data", inst_data, {mq[1], mq[0]});
          chk("is_c", {31'h0, inst_is_c}, 32'h0);
        end
      end
      if (rst) cyc = 0;
      else cyc++;
      if (inst_valid && inst_ready) begin
        lg_pc.push_back(inst_pc);
        lg_data.push_back(inst_data);
        lg_c.push_back(inst_is_c);
        lg_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    lg_pc.delete();
    lg_data.delete();
    lg_c.delete();
    lg_cyc.delete();
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [31:0] pc,
                         input logic [31:0] data, input logic c);
    if (idx >= lg_pc.size()) begin
      checks++;
      failures++;
      $display("FAIL %s: only %0d instructions seen, entry %0d required", nm, lg_pc.size(), idx);
    end else begin
      chk({nm, "_pc"}, lg_pc[idx], pc);
      chk({nm, "_data"}, lg_data[idx], data);
      chk({nm, "_is_c"}, {31'h0, lg_c[idx]}, {31'h0, c});
    end
  endtask

  initial begin
    rst            = 1'b1;
    ICACHE_stall   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = (32'(i) << 20) | 32'h13;

    // Aligned 32-bit stream from reset.
    tick();
    tick();
    rst = 1'b0;
    clear_log();
    repeat (12) tick();
    for (int k = 0; k < 4; k++)
      chk_log("s1", k, 32'(4 * k), (32'(k) << 20) | 32'h13, 1'b0);
    if (lg_cyc.size() > 0) chk("s1_first_cycle", 32'(lg_cyc[0]), 32'd2);

    // Compressed followed by a straddling 32-bit instruction.
    mem[0] = 32'h0513_0001;
    mem[1] = 32'h0000_0083;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_log();
    repeat (8) tick();
    chk_log("s2_0", 0, 32'h0, 32'h0000_0001, 1'b1);
    chk_log("s2_1", 1, 32'h2, 32'h0083_0513, 1'b0);
    chk_log("s2_2", 2, 32'h6, 32'h0000_0000, 1'b1);
    chk_log("s2_3", 3, 32'h8, 32'h0020_0013, 1'b0);

    // Redirect to a halfword-aligned target.
    mem[8'h41] = 32'h4501_FFFF;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0106;
    tick();
    redirect_valid = 1'b0;
    chk("s3_addr", {2'b00, ICACHE_addr}, 32'h41);
    chk("s3_ren", {31'h0, ICACHE_ren}, 32'h1);
    clear_log();
    tick();
    chk("s3_valid", {31'h0, inst_valid}, 32'h1);
    chk("s3_pc", inst_pc, 32'h106);
    chk("s3_data", inst_data, 32'h0000_4501);
    repeat (4) tick();
    chk_log("s3_0", 0, 32'h106, 32'h0000_4501, 1'b1);
    chk_log("s3_1", 1, 32'h108, 32'h0420_0013, 1'b0);

    // Redirects while a cache access is stalled.
    mem[0]     = 32'h0001_0001;
    mem[8'h80] = 32'h00A0_0513;
    ICACHE_stall = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    clear_log();
    chk("s4_addr1", {2'b00, ICACHE_addr}, 32'h0);
    chk("s4_valid1", {31'h0, inst_valid}, 32'h0);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    chk("s4_addr2", {2'b00, ICACHE_addr}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      redirect_valid = 1'b0;
      chk("s4_addr_hold", {2'b00, ICACHE_addr}, 32'h0);
      chk("s4_ren_hold", {31'h0, ICACHE_ren}, 32'h1);
    end
    ICACHE_stall = 1'b0;
    tick();
    chk("s4_addr_target", {2'b00, ICACHE_addr}, 32'h80);
    chk("s4_valid_none", {31'h0, inst_valid}, 32'h0);
    repeat (6) tick();
    chk_log("s4_0", 0, 32'h200, 32'h00A0_0513, 1'b0);
    chk_log("s4_1", 1, 32'h204, 32'h0810_0013, 1'b0);

    // Backpressure with a full buffer.
    mem[8'hC0] = 32'h0093_FFFF;
    mem[8'hC1] = 32'h0001_0010;
    mem[8'hC2] = 32'h0001_0001;
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0302;
    tick();
    redirect_valid = 1'b0;
    clear_log();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s5_valid", {31'h0, inst_valid}, 32'h1);
      chk("s5_ren", {31'h0, ICACHE_ren}, 32'h0);
      chk("s5_data", inst_data, 32'h0010_0093);
      chk("s5_pc", inst_pc, 32'h302);
    end
    inst_ready = 1'b1;
    repeat (6) tick();
    chk_log("s5_0", 0, 32'h302, 32'h0010_0093, 1'b0);
    chk_log("s5_1", 1, 32'h306, 32'h0000_0001, 1'b1);
    chk_log("s5_2", 2, 32'h308, 32'h0000_0001, 1'b1);
    chk_log("s5_3", 3, 32'h30A, 32'h0000_0001, 1'b1);

    // Reset while a request is stalled.
    ICACHE_stall = 1'b1;
    for (int i = 0; i < 10 && !ICACHE_ren; i++) tick();
    chk("s6_ren_before", {31'h0, ICACHE_ren}, 32'h1);
    rst = 1'b1;
    #1;
    chk("s6_ren_in_rst", {31'h0, ICACHE_ren}, 32'h0);
    tick();
    chk("s6_valid", {31'h0, inst_valid}, 32'h0);
    chk("s6_ren", {31'h0, ICACHE_ren}, 32'h0);
    chk("s6_pc", inst_pc, RESET_PC);
    rst = 1'b0;
    ICACHE_stall = 1'b0;
    #1;
    chk("s6_ren_after", {31'h0, ICACHE_ren}, 32'h1);
    chk("s6_addr_after", {2'b00, ICACHE_addr}, {2'b00, RESET_PC[31:2]});
    clear_log();
    repeat (6) tick();
    chk_log("s6_0", 0, 32'h0, 32'h0000_0001, 1'b1);
    chk_log("s6_1", 1, 32'h2, 32'h0000_0001, 1'b1);
    chk_log("s6_2", 2, 32'h4, 32'h0000_0083, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
